// File: rtl/sd_sector_buffer_pkg.sv
// Shared definitions for the SD sector ping-pong buffer.
//   SD_DATA_W       : stream word width
//   SD_SECTOR_WORDS : words per 512-byte sector
//   wr_state_e      : capture-side state (fill / drop-until-TLAST)
//   rd_state_e      : replay-side read-issue state
package sd_sector_buffer_pkg;
    localparam int SD_DATA_W       = 16;
    localparam int SD_SECTOR_WORDS = 256;

    typedef enum logic {
        W_FILL = 1'b0,
        W_DROP = 1'b1
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_PREF   = 2'd1,
        R_STREAM = 2'd2
    } rd_state_e;
endpackage

// File: rtl/sd_sector_ram.sv
// Simple dual-port sector memory holding both ping-pong banks.
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request; rd_data valid the cycle after rd_en
//   rd_data          : registered read data, holds while rd_en is low
// Address is {bank, word}; the banks are never written and read at the same
// address in the same cycle, so read-during-write ordering is irrelevant.
module sd_sector_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/sd_sector_buffer.sv
// Ping-pong sector buffer: captures the SPI reader's sector stream into one of
// two banks and replays completed sectors on an AXI-Stream master.
//   sd_clk, sd_rst              : clock, synchronous active-high reset
//   SectorData_TVALID/TDATA/TLAST: input stream, no backpressure
//   buf_ready                   : current write bank free, a new read may start
//   M_TVALID/TDATA/TLAST/TREADY : output stream with backpressure
//   overrun, len_err            : sticky error flags, cleared by clr_err
//   sector_cnt                  : sectors fully drained (wraps)
module sd_sector_buffer
    import sd_sector_buffer_pkg::*;
#(
    parameter int DATA_W       = SD_DATA_W,
    parameter int SECTOR_WORDS = SD_SECTOR_WORDS
) (
    input  logic              sd_clk,
    input  logic              sd_rst,
    input  logic              SectorData_TVALID,
    input  logic [DATA_W-1:0] SectorData_TDATA,
    input  logic              SectorData_TLAST,
    output logic              buf_ready,
    output logic              M_TVALID,
    output logic [DATA_W-1:0] M_TDATA,
    output logic              M_TLAST,
    input  logic              M_TREADY,
    output logic              overrun,
    output logic              len_err,
    input  logic              clr_err,
    output logic [15:0]       sector_cnt
);
    localparam int WPTR_W = $clog2(SECTOR_WORDS);
    localparam logic [WPTR_W-1:0] LAST_PTR = WPTR_W'(SECTOR_WORDS - 1);

    // Capture side
    wr_state_e         wr_state_q, wr_state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [WPTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              buf_ready_q, buf_ready_d;
    logic              overrun_q, overrun_d;
    logic              len_err_q, len_err_d;
    logic              wr_en, commit;

    // Replay side: iss_bank/rd_ptr run ahead of rd_bank, which only moves
    // when a sector's TLAST beat leaves, so the next bank can be prefetched.
    rd_state_e         rd_state_q, rd_state_d;
    logic              iss_bank_q, iss_bank_d;
    logic [WPTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              rd_bank_q, rd_bank_d;
    logic              ram_vld_q, ram_vld_d;
    logic              ram_last_q, ram_last_d;
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [15:0]       sector_cnt_q, sector_cnt_d;
    logic              rd_en, out_load, room, release_bank;
    logic [DATA_W-1:0] ram_rd_data;

    sd_sector_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (WPTR_W + 1)
    ) u_ram (
        .clk     (sd_clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank_q, wr_ptr_q}),
        .wr_data (SectorData_TDATA),
        .rd_en   (rd_en),
        .rd_addr ({iss_bank_q, rd_ptr_q}),
        .rd_data (ram_rd_data)
    );

    // Commit and release always hit different banks (one is empty, the other
    // full), so both may take effect on the same edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign bank_full_d[gi] = (commit && (wr_bank_q == 1'(gi)))
                               | (bank_full_q[gi] & ~(release_bank && (rd_bank_q == 1'(gi))));
    end

    assign buf_ready_d = ~bank_full_d[wr_bank_d] & (wr_state_d == W_FILL);

    always_comb begin
        wr_state_d = wr_state_q;
        wr_bank_d  = wr_bank_q;
        wr_ptr_d   = wr_ptr_q;
        // Clear first so a coincident error event re-sets the flag.
        overrun_d  = clr_err ? 1'b0 : overrun_q;
        len_err_d  = clr_err ? 1'b0 : len_err_q;
        wr_en      = 1'b0;
        commit     = 1'b0;
        case (wr_state_q)
            W_FILL: begin
                if (SectorData_TVALID) begin
                    if (!bank_full_q[wr_bank_q]) begin
                        wr_en = 1'b1;
                        if (wr_ptr_q == LAST_PTR) begin
                            commit    = 1'b1;
                            wr_bank_d = ~wr_bank_q;
                            wr_ptr_d  = '0;
                            if (!SectorData_TLAST) begin
                                len_err_d  = 1'b1;
                                wr_state_d = W_DROP;
                            end
                        end else if (SectorData_TLAST) begin
                            // Short sector: abandon it, bank stays uncommitted.
                            len_err_d = 1'b1;
                            wr_ptr_d  = '0;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end else begin
                        overrun_d = 1'b1;
                        if (!SectorData_TLAST) begin
                            wr_state_d = W_DROP;
                        end
                    end
                end
            end
            W_DROP: begin
                if (SectorData_TVALID && SectorData_TLAST) begin
                    wr_state_d = W_FILL;
                end
            end
            default: wr_state_d = W_FILL;
        endcase
    end

    always_comb begin
        // Output register takes the RAM word whenever it is empty or draining.
        out_load     = ram_vld_q & (~out_vld_q | M_TREADY);
        // A new read may only overwrite the RAM register once its word moves on.
        room         = ~ram_vld_q | out_load;
        release_bank = out_vld_q & M_TREADY & out_last_q;

        rd_state_d   = rd_state_q;
        iss_bank_d   = iss_bank_q;
        rd_ptr_d     = rd_ptr_q;
        rd_bank_d    = rd_bank_q;
        sector_cnt_d = sector_cnt_q;
        rd_en        = 1'b0;

        case (rd_state_q)
            R_IDLE: begin
                if (bank_full_q[iss_bank_q]) begin
                    rd_state_d = R_PREF;
                end
            end
            R_PREF, R_STREAM: begin
                if (room) begin
                    rd_en = 1'b1;
                    if (rd_ptr_q == LAST_PTR) begin
                        rd_ptr_d   = '0;
                        iss_bank_d = ~iss_bank_q;
                        // Chain straight into the other bank when it is
                        // already full so the output has no bubble.
                        rd_state_d = bank_full_q[~iss_bank_q] ? R_PREF : R_IDLE;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        rd_state_d = R_STREAM;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        ram_vld_d  = ram_vld_q;
        ram_last_d = ram_last_q;
        if (rd_en) begin
            ram_vld_d  = 1'b1;
            ram_last_d = (rd_ptr_q == LAST_PTR);
        end else if (out_load) begin
            ram_vld_d = 1'b0;
        end

        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        if (out_load) begin
            out_vld_d  = 1'b1;
            out_data_d = ram_rd_data;
            out_last_d = ram_last_q;
        end else if (M_TREADY) begin
            out_vld_d = 1'b0;
        end

        if (release_bank) begin
            rd_bank_d    = ~rd_bank_q;
            sector_cnt_d = sector_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sd_clk) begin
        if (sd_rst) begin
            wr_state_q   <= W_FILL;
            wr_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            bank_full_q  <= 2'b00;
            buf_ready_q  <= 1'b1;
            overrun_q    <= 1'b0;
            len_err_q    <= 1'b0;
            rd_state_q   <= R_IDLE;
            iss_bank_q   <= 1'b0;
            rd_ptr_q     <= '0;
            rd_bank_q    <= 1'b0;
            ram_vld_q    <= 1'b0;
            ram_last_q   <= 1'b0;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            sector_cnt_q <= 16'd0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_bank_q    <= wr_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            bank_full_q  <= bank_full_d;
            buf_ready_q  <= buf_ready_d;
            overrun_q    <= overrun_d;
            len_err_q    <= len_err_d;
            rd_state_q   <= rd_state_d;
            iss_bank_q   <= iss_bank_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_bank_q    <= rd_bank_d;
            ram_vld_q    <= ram_vld_d;
            ram_last_q   <= ram_last_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            sector_cnt_q <= sector_cnt_d;
        end
    end

    assign buf_ready  = buf_ready_q;
    assign M_TVALID   = out_vld_q;
    assign M_TDATA    = out_data_q;
    assign M_TLAST    = out_last_q;
    assign overrun    = overrun_q;
    assign len_err    = len_err_q;
    assign sector_cnt = sector_cnt_q;
endmodule
